// File: rtl/fifo_srl_mc.sv
// fifo_srl_mc: N_CHAN-lane first-word-fall-through SRL FIFO; define FIFO_SRL_MC_OREG_EN for a per-lane output register
module fifo_srl_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int N_CHAN     = 2,
  parameter int AF_LEVEL   = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_CHAN-1:0]                if_write,
  input  logic [N_CHAN*DATA_WIDTH-1:0]     if_din,
  output logic [N_CHAN-1:0]                if_full_n,
  output logic [N_CHAN-1:0]                if_almost_full,
  input  logic [N_CHAN-1:0]                if_read,
  output logic [N_CHAN*DATA_WIDTH-1:0]     if_dout,
  output logic [N_CHAN-1:0]                if_empty_n,
  output logic [N_CHAN*(ADDR_WIDTH+1)-1:0] if_count
);
  localparam int CW = ADDR_WIDTH + 1;
`ifdef FIFO_SRL_MC_OREG_EN
  localparam int CAP = DEPTH + 1;
`else
  localparam int CAP = DEPTH;
`endif
  for (genvar k = 0; k < N_CHAN; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] din, head;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0] sc, sc_nx, cnt_nx;
    logic wr, rd, push, pop, vis_nx;
    logic full_n, empty_n, almost_full;
    assign din = if_din[k*DATA_WIDTH +: DATA_WIDTH];
    assign head = mem[addr];
    assign wr = if_write[k] & full_n;
    assign rd = if_read[k] & empty_n;
    assign push = wr;
    assign sc_nx = sc + CW'(push) - CW'(pop);
    assign if_full_n[k] = full_n;
    assign if_empty_n[k] = empty_n;
    assign if_almost_full[k] = almost_full;
`ifdef FIFO_SRL_MC_OREG_EN
    logic ov, load, ov_nx;
    logic [DATA_WIDTH-1:0] oreg;
    assign load = (!ov || rd) && sc != '0;
    assign pop = load;
    assign ov_nx = load || (ov && !rd);
    assign cnt_nx = sc_nx + CW'(ov_nx);
    assign vis_nx = ov_nx;
    assign if_dout[k*DATA_WIDTH +: DATA_WIDTH] = oreg;
    assign if_count[k*CW +: CW] = sc + CW'(ov);
    // output register holds the visible head word and refills from the SRL head
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        ov <= 1'b0;
        oreg <= '0;
      end else begin
        ov <= ov_nx;
        if (load) oreg <= head;
      end
`else
    assign pop = rd;
    assign cnt_nx = sc_nx;
    assign vis_nx = cnt_nx != '0;
    assign if_dout[k*DATA_WIDTH +: DATA_WIDTH] = head;
    assign if_count[k*CW +: CW] = sc;
`endif
    // SRL shifts on every accepted write; contents are intentionally not reset
    always_ff @(posedge clk)
      if (push) begin
        mem[0] <= din;
        for (int i = 1; i < DEPTH; i++) mem[i] <= mem[i-1];
      end
    // SRL occupancy and head address; addr stays pinned at 0 across the 0<->1 transitions
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        sc <= '0;
        addr <= '0;
      end else begin
        sc <= sc_nx;
        addr <= (push && !pop && sc != '0) ? addr + 1'b1 :
                (pop && !push && sc != CW'(1)) ? addr - 1'b1 : addr;
      end
    // handshake flags registered from the next total occupancy
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        full_n <= 1'b1;
        empty_n <= 1'b0;
        almost_full <= 1'b0;
      end else begin
        full_n <= cnt_nx != CW'(CAP);
        empty_n <= vis_nx;
        almost_full <= cnt_nx >= CW'(AF_LEVEL);
      end
  end
endmodule

// File: tb/tb_fifo_srl_mc.sv
// tb_fifo_srl_mc: table vectors, corner sequences and random traffic against a queue model
module tb_fifo_srl_mc;
  localparam int DW = 32, DEPTH = 16, AW = 4, NC = 2, AF = 12;
  logic clk = 0, reset = 1;
  logic [NC-1:0] if_write = '0, if_read = '0;
  logic [NC-1:0] if_full_n, if_almost_full, if_empty_n;
  logic [NC*DW-1:0] if_din = '0, if_dout;
  logic [NC*(AW+1)-1:0] if_count;
  int checks = 0, failures = 0;
  logic [DW-1:0] q[NC][$];
  typedef struct {
    logic w, r;
    logic [DW-1:0] d;
    int cnt;
    logic en, fn;
    logic [DW-1:0] dout;
  } vec_t;
  vec_t tv[8];

  always #5 clk = ~clk;

  fifo_srl_mc #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .N_CHAN(NC), .AF_LEVEL(AF)) dut (
    .clk(clk), .reset(reset), .if_write(if_write), .if_din(if_din), .if_full_n(if_full_n),
    .if_almost_full(if_almost_full), .if_read(if_read), .if_dout(if_dout),
    .if_empty_n(if_empty_n), .if_count(if_count));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NC; k++) begin
      int n;
      n = q[k].size();
      chk($sformatf("count%0d", k), 64'(if_count[k*(AW+1) +: AW+1]), 64'(n));
      chk($sformatf("empty_n%0d", k), 64'(if_empty_n[k]), 64'(n != 0));
      chk($sformatf("full_n%0d", k), 64'(if_full_n[k]), 64'(n != DEPTH));
      chk($sformatf("almost_full%0d", k), 64'(if_almost_full[k]), 64'(n >= AF));
      if (n != 0) chk($sformatf("dout%0d", k), 64'(if_dout[k*DW +: DW]), 64'(q[k][0]));
    end
  endtask

  task automatic cyc(input logic [NC-1:0] w, input logic [NC-1:0] r,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    bit [NC-1:0] aw, ar;
    if_write = w;
    if_read = r;
    if_din = {d1, d0};
    for (int k = 0; k < NC; k++) begin
      aw[k] = w[k] && q[k].size() < DEPTH;
      ar[k] = r[k] && q[k].size() > 0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      if (ar[k]) void'(q[k].pop_front());
      if (aw[k]) q[k].push_back(k == 0 ? d0 : d1);
    end
    if_write = '0;
    if_read = '0;
    check_all();
  endtask

  initial begin
    tv[0] = '{1, 0, 32'hA5A5_0001, 1, 1, 1, 32'hA5A5_0001};
    tv[1] = '{1, 0, 32'h0000_0002, 2, 1, 1, 32'hA5A5_0001};
    tv[2] = '{1, 1, 32'h0000_0003, 2, 1, 1, 32'h0000_0002};
    tv[3] = '{0, 1, 32'h0,         1, 1, 1, 32'h0000_0003};
    tv[4] = '{0, 1, 32'h0,         0, 0, 1, 32'h0};
    tv[5] = '{0, 1, 32'h0,         0, 0, 1, 32'h0};
    tv[6] = '{1, 1, 32'h0000_0007, 1, 1, 1, 32'h0000_0007};
    tv[7] = '{0, 0, 32'h0,         1, 1, 1, 32'h0000_0007};

    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 0;

    for (int i = 0; i < 8; i++) begin
      cyc({1'b0, tv[i].w}, {1'b0, tv[i].r}, tv[i].d, '0);
      chk($sformatf("tv%0d_count", i), 64'(if_count[0 +: AW+1]), 64'(tv[i].cnt));
      chk($sformatf("tv%0d_empty_n", i), 64'(if_empty_n[0]), 64'(tv[i].en));
      chk($sformatf("tv%0d_full_n", i), 64'(if_full_n[0]), 64'(tv[i].fn));
      if (tv[i].en) chk($sformatf("tv%0d_dout", i), 64'(if_dout[0 +: DW]), 64'(tv[i].dout));
      chk($sformatf("tv%0d_lane1_empty_n", i), 64'(if_empty_n[1]), 64'(0));
    end

    for (int i = 0; i < DEPTH + 1; i++) begin
      cyc(2'b10, 2'b00, '0, DW'(i));
      if (i == AF - 1) chk("af_after_12th", 64'(if_almost_full[1]), 64'(1));
      if (i == AF - 2) chk("af_before_12th", 64'(if_almost_full[1]), 64'(0));
    end
    chk("full_after_17", 64'(if_full_n[1]), 64'(0));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), 64'(if_dout[DW +: DW]), 64'(i));
      cyc(2'b00, 2'b10, '0, '0);
    end
    chk("drained_empty_n", 64'(if_empty_n[1]), 64'(0));

    for (int i = 0; i < DEPTH; i++) cyc(2'b10, 2'b00, '0, DW'(100 + i));
    cyc(2'b10, 2'b10, '0, 32'hDEAD);
    chk("full_wr_rd_count", 64'(if_count[AW+1 +: AW+1]), 64'(DEPTH - 1));
    chk("full_wr_rd_full_n", 64'(if_full_n[1]), 64'(1));

    while (q[0].size() < 5) cyc(2'b01, 2'b00, $urandom, '0);
    for (int i = 0; i < 20; i++) cyc(2'b01, 2'b01, 32'h5000 + i, '0);
    chk("steady_count5", 64'(if_count[0 +: AW+1]), 64'(5));

    while (q[0].size() < 9) cyc(2'b01, 2'b00, $urandom, '0);
    #2 reset = 1;
    #1;
    for (int k = 0; k < NC; k++) q[k].delete();
    check_all();
    @(negedge clk);
    reset = 0;
    cyc(2'b01, 2'b00, 32'hBEEF_0001, '0);
    chk("post_reset_dout", 64'(if_dout[0 +: DW]), 64'hBEEF_0001);

    for (int i = 0; i < 3000; i++) begin
      logic [NC-1:0] w, r;
      int pw;
      pw = ((i / 150) % 2 == 0) ? 75 : 25;
      for (int k = 0; k < NC; k++) begin
        w[k] = $urandom_range(99) < pw;
        r[k] = $urandom_range(99) < 100 - pw;
      end
      cyc(w, r, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
